// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, N data bits LSB first, even-parity bit, stop bit.
// Each bit is held for CLKS_PER_BIT cycles; all outputs come straight from flops.
module parity_frame_tx #(
  parameter int unsigned N            = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] data_in,
  input  logic         valid_in,
  output logic         ready_out,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     shift_q, shift_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;

  // Next-state logic; tx is derived from the next state so it lines up with the state register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    bit_end = (cnt_q == CNT_LAST);

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          state_d = S_START;
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = data_in;
          par_d   = ^data_in;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            state_d = S_PARITY;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx        = tx_q;
  assign ready_out = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: two instances (N=8/4 clocks per bit, N=4/1 clock per bit)
// compared cycle by cycle against a frame model built from the bit-slot rules.
module tb_parity_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_a;
  logic       valid_a;
  logic       ready_a, tx_a, busy_a, done_a;
  logic [3:0] data_b;
  logic       valid_b;
  logic       ready_b, tx_b, busy_b, done_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  parity_frame_tx #(.N(8), .CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_a), .valid_in(valid_a),
    .ready_out(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  parity_frame_tx #(.N(4), .CLKS_PER_BIT(1)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_b), .valid_in(valid_b),
    .ready_out(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame = slot 0 start, slots 1..n data LSB first, slot n+1 parity, slot n+2 stop.
  function automatic logic model_tx(input logic [7:0] d, input int n, input int c, input int i);
    int slot;
    int ones;
    slot = i / c;
    if (slot == 0) return 1'b0;
    if (slot <= n) return d[slot-1];
    if (slot == n + 1) begin
      ones = 0;
      for (int k = 0; k < n; k++) ones += int'(d[k]);
      return logic'(ones % 2);
    end
    return 1'b1;
  endfunction

  task automatic check_idle(input bit sel, input string tag);
    check({tag, " tx"},    sel ? tx_b    : tx_a,    1);
    check({tag, " ready"}, sel ? ready_b : ready_a, 1);
    check({tag, " busy"},  sel ? busy_b  : busy_a,  0);
    check({tag, " done"},  sel ? done_b  : done_a,  0);
  endtask

  // Caller has set valid/data at a negedge; returns at the negedge of the done cycle.
  task automatic frame(input bit sel, input logic [7:0] d, input bit nv,
                       input logic [7:0] nd, input string tag);
    int   n;
    int   c;
    int   len;
    int   ones;
    logic t;
    n   = sel ? 4 : 8;
    c   = sel ? 1 : 4;
    len = (n + 3) * c;
    @(posedge clk);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (sel) begin valid_b = nv; data_b = nd[3:0]; end
        else     begin valid_a = nv; data_a = nd;      end
      end
      t = sel ? tx_b : tx_a;
      check($sformatf("%s tx[%0d]", tag, i), t, model_tx(d, n, c, i));
      check($sformatf("%s ready[%0d]", tag, i), sel ? ready_b : ready_a, 0);
      check($sformatf("%s busy[%0d]", tag, i),  sel ? busy_b  : busy_a,  1);
      check($sformatf("%s done[%0d]", tag, i),  sel ? done_b  : done_a,  0);
      if (i == (n + 1) * c) begin
        ones = int'(t);
        for (int k = 0; k < n; k++) ones += int'(d[k]);
        check({tag, " even ones"}, ones % 2, 0);
      end
    end
    @(negedge clk);
    check({tag, " done pulse"}, sel ? done_b  : done_a,  1);
    check({tag, " end ready"},  sel ? ready_b : ready_a, 1);
    check({tag, " end tx"},     sel ? tx_b    : tx_a,    1);
    check({tag, " end busy"},   sel ? busy_b  : busy_a,  0);
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] w2;
    rst     = 1'b1;
    valid_a = 1'b0;
    data_a  = '0;
    valid_b = 1'b0;
    data_b  = '0;

    @(negedge clk);
    check_idle(0, "reset a");
    check_idle(1, "reset b");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle(0, $sformatf("idle a %0d", i));
      check_idle(1, $sformatf("idle b %0d", i));
    end

    valid_a = 1'b1; data_a = 8'b0000_0011;
    frame(0, 8'b0000_0011, 0, 8'h00, "f03");
    @(negedge clk);
    valid_a = 1'b1; data_a = 8'b1000_1001;
    frame(0, 8'b1000_1001, 0, 8'h00, "f89");

    // Word held on valid_in during a frame is only taken on the done cycle.
    @(negedge clk);
    valid_a = 1'b1; data_a = 8'hA5;
    frame(0, 8'hA5, 1, 8'h3C, "holdA5");
    frame(0, 8'h3C, 0, 8'h00, "hold3C");

    // Reset in the middle of the DATA phase.
    @(negedge clk);
    valid_a = 1'b1; data_a = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    repeat (9) @(negedge clk);
    check("pre-rst busy", busy_a, 1);
    rst = 1'b1;
    #1;
    check("rst tx", tx_a, 1);
    check("rst ready", ready_a, 1);
    check("rst busy", busy_a, 0);
    check("rst done", done_a, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_idle(0, $sformatf("post-rst %0d", i));
    end
    w = 8'($urandom);
    valid_a = 1'b1; data_a = w;
    frame(0, w, 0, 8'h00, "after-rst");

    @(negedge clk);
    valid_b = 1'b1; data_b = 4'b0111;
    frame(1, 8'h07, 0, 8'h00, "b0111");

    // Randomized words, alternating idle gaps and back-to-back frames.
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      w  = 8'($urandom);
      w2 = 8'($urandom);
      valid_a = 1'b1; data_a = w;
      frame(0, w, 1, w2, $sformatf("rndA%0d", r));
      frame(0, w2, 0, 8'h00, $sformatf("rndA%0db", r));
    end
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      w = 8'($urandom_range(0, 15));
      valid_b = 1'b1; data_b = w[3:0];
      frame(1, w, 0, 8'h00, $sformatf("rndB%0d", r));
    end

    @(negedge clk);
    check_idle(0, "final a");
    check_idle(1, "final b");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
